button_conditioner: RTL and testbench

Conditions the three raw, active-low push-button inputs into the clean `left`, `right` and `jump` controls consumed by the Mario movement stage.

- Per-button processing: two-flop synchronization, counter-based debounce, then registered output.
- Jump gating: the jump output is limited to a bounded hold window per press, and re-arms only after a release.
- Placement: directly upstream of the mover, clocked by the VGA clock, and it replaces the direct key wiring.

---
 rtl/button_conditioner.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_button_conditioner.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//   Turns the three raw, active-low push buttons into the clean controls used
//   by the Mario movement stage. Each key goes through a 2-flop synchronizer
//   and a counter-based debouncer. The debounced levels are then registered.
//   The jump channel also passes through a gate. The gate bounds how long
//   jump stays asserted per press, and it only re-arms after a release.
//
//   Parameters
//     DEBOUNCE_CYCLES   consecutive stable synced cycles to accept a change (>=1)
//     JUMP_HOLD_CYCLES  maximum cycles jump stays asserted per press (>=1)
//
//   Ports
//     vga_clock    in   sole clock, rising edge
//     reset        in   asynchronous, active-low reset
//     key_left_n   in   raw left key, 0 = pressed
//     key_right_n  in   raw right key, 0 = pressed
//     key_jump_n   in   raw jump key, 0 = pressed
//     left         out  debounced left request, active-high
//     right        out  debounced right request, active-high
//     jump         out  gated jump request, active-low (the mover inverts it)
//     jump_pulse   out  one-cycle strobe on each accepted jump press
//
//   Build option
//     BUTTON_CONDITIONER_LR_EXCLUSIVE_EN : when defined, left/right are made
//     mutually exclusive. The most recently pressed direction wins. If both
//     are accepted on the same cycle, neither is output until one is released.
// ---------------------------------------------------------------------------

// Per-key synchronizer + debouncer. The output is the accepted level (1 = pressed).
module button_conditioner_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] S_RELEASED     = 2'd0;
  localparam logic [1:0] S_PRESS_PEND   = 2'd1;
  localparam logic [1:0] S_PRESSED      = 2'd2;
  localparam logic [1:0] S_RELEASE_PEND = 2'd3;

  logic             r_sync1;
  logic             r_sync2;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pressed;

  // Synchronizer flops come out of reset as "released". A key that is held
  // through reset then shows up as a fresh press and has to debounce fully.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make the two flops a real 2-stage chain;
      // blocking ones would collapse it into a single stage.
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = ~r_sync2;

  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_RELEASED: begin
        if (w_pressed) begin
          w_state_nxt = S_PRESS_PEND;
          w_cnt_nxt   = '0;
        end
      end
      S_PRESS_PEND: begin
        if (!w_pressed) begin
          w_state_nxt = S_RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_PRESSED: begin
        if (!w_pressed) begin
          w_state_nxt = S_RELEASE_PEND;
          w_cnt_nxt   = '0;
        end
      end
      S_RELEASE_PEND: begin
        if (w_pressed) begin
          w_state_nxt = S_PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_RELEASED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_level = (r_state == S_PRESSED) || (r_state == S_RELEASE_PEND);

endmodule


module button_conditioner #(
  parameter int DEBOUNCE_CYCLES  = 250000,
  parameter int JUMP_HOLD_CYCLES = 12500000
) (
  input  logic vga_clock,
  input  logic reset,
  input  logic key_left_n,
  input  logic key_right_n,
  input  logic key_jump_n,
  output logic left,
  output logic right,
  output logic jump,
  output logic jump_pulse
);

  localparam int HOLD_W = $clog2(JUMP_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(JUMP_HOLD_CYCLES - 1);

  localparam logic [1:0] J_IDLE    = 2'd0;
  localparam logic [1:0] J_HOLD    = 2'd1;
  localparam logic [1:0] J_LOCKOUT = 2'd2;

  logic              w_db_left;
  logic              w_db_right;
  logic              w_db_jump;
  logic              w_left_nxt;
  logic              w_right_nxt;

  logic [1:0]        r_jstate;
  logic [1:0]        w_jstate_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              r_db_jump_prev;
  logic              w_jump_rise;
  logic              w_pulse_nxt;

  logic              r_left;
  logic              r_right;
  logic              r_jump;
  logic              r_jump_pulse;

  button_conditioner_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .i_clk   (vga_clock),
    .i_rst_n (reset),
    .i_key_n (key_left_n),
    .o_level (w_db_left)
  );

  button_conditioner_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .i_clk   (vga_clock),
    .i_rst_n (reset),
    .i_key_n (key_right_n),
    .o_level (w_db_right)
  );

  button_conditioner_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_jump (
    .i_clk   (vga_clock),
    .i_rst_n (reset),
    .i_key_n (key_jump_n),
    .o_level (w_db_jump)
  );

  // ---------------- left / right ----------------
`ifdef BUTTON_CONDITIONER_LR_EXCLUSIVE_EN
  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_LEFT  = 2'd1;
  localparam logic [1:0] OWN_RIGHT = 2'd2;

  logic       r_db_left_prev;
  logic       r_db_right_prev;
  logic [1:0] r_owner;
  logic [1:0] w_owner_nxt;
  logic       w_left_rise;
  logic       w_right_rise;

  assign w_left_rise  = w_db_left  & ~r_db_left_prev;
  assign w_right_rise = w_db_right & ~r_db_right_prev;

  // The owner is the most recently accepted direction. It is resolved in the
  // same cycle the press is accepted, so exclusivity adds no latency.
  always_comb begin
    w_owner_nxt = r_owner;
    if (w_left_rise && w_right_rise) begin
      w_owner_nxt = OWN_NONE;
    end else if (w_left_rise) begin
      w_owner_nxt = OWN_LEFT;
    end else if (w_right_rise) begin
      w_owner_nxt = OWN_RIGHT;
    end
  end

  // A lone held direction always passes. Ownership only matters when both are held.
  assign w_left_nxt  = w_db_left  & (~w_db_right | (w_owner_nxt == OWN_LEFT));
  assign w_right_nxt = w_db_right & (~w_db_left  | (w_owner_nxt == OWN_RIGHT));

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      r_db_left_prev  <= 1'b0;
      r_db_right_prev <= 1'b0;
      r_owner         <= OWN_NONE;
    end else begin
      r_db_left_prev  <= w_db_left;
      r_db_right_prev <= w_db_right;
      r_owner         <= w_owner_nxt;
    end
  end
`else
  assign w_left_nxt  = w_db_left;
  assign w_right_nxt = w_db_right;
`endif

  // ---------------- jump gate ----------------
  assign w_jump_rise = w_db_jump & ~r_db_jump_prev;

  always_comb begin
    w_jstate_nxt = r_jstate;
    w_hold_nxt   = r_hold_cnt;
    w_pulse_nxt  = 1'b0;
    case (r_jstate)
      J_IDLE: begin
        if (w_jump_rise) begin
          w_jstate_nxt = J_HOLD;
          w_hold_nxt   = '0;
          w_pulse_nxt  = 1'b1;
        end
      end
      J_HOLD: begin
        // A release takes priority over the window expiring.
        if (!w_db_jump) begin
          w_jstate_nxt = J_IDLE;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_jstate_nxt = J_LOCKOUT;
        end else begin
          w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      J_LOCKOUT: begin
        if (!w_db_jump) begin
          w_jstate_nxt = J_IDLE;
        end
      end
      default: begin
        w_jstate_nxt = J_IDLE;
        w_hold_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      r_jstate       <= J_IDLE;
      r_hold_cnt     <= '0;
      r_db_jump_prev <= 1'b0;
      r_left         <= 1'b0;
      r_right        <= 1'b0;
      r_jump         <= 1'b1;
      r_jump_pulse   <= 1'b0;
    end else begin
      r_jstate       <= w_jstate_nxt;
      r_hold_cnt     <= w_hold_nxt;
      r_db_jump_prev <= w_db_jump;
      r_left         <= w_left_nxt;
      r_right        <= w_right_nxt;
      // jump is registered from the next gate state. It therefore changes
      // on the same edge as the gate transition.
      r_jump         <= (w_jstate_nxt != J_HOLD);
      r_jump_pulse   <= w_pulse_nxt;
    end
  end

  assign left       = r_left;
  assign right      = r_right;
  assign jump       = r_jump;
  assign jump_pulse = r_jump_pulse;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int D = 4;
  localparam int H = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic key_l = 1'b1;
  logic key_r = 1'b1;
  logic key_j = 1'b1;
  logic left, right, jump, jump_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .JUMP_HOLD_CYCLES(H)) dut (
    .vga_clock   (clk),
    .reset       (rst_n),
    .key_left_n  (key_l),
    .key_right_n (key_r),
    .key_jump_n  (key_j),
    .left        (left),
    .right       (right),
    .jump        (jump),
    .jump_pulse  (jump_pulse)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Channel index: 0 = left, 1 = right, 2 = jump.
  logic [2:0] m_s1, m_s2;   // raw samples delayed through the synchronizer
  logic [2:0] m_lvl;        // accepted level, 1 = pressed
  logic [2:0] m_prev;       // accepted level one edge earlier
  int         m_run[3];     // consecutive synced samples that disagree with m_lvl
  int         m_t_rise[3];  // edge number of the latest accepted press
  int         m_cyc;
  bit         m_jlow;       // jump currently asserted
  int         m_held;       // cycles jump has been asserted for this press
  logic       e_left, e_right, e_jump, e_pulse;

  task automatic model_reset();
    m_s1   = 3'b111;
    m_s2   = 3'b111;
    m_lvl  = 3'b000;
    m_prev = 3'b000;
    for (int c = 0; c < 3; c++) begin
      m_run[c]    = 0;
      m_t_rise[c] = 0;
    end
    m_jlow  = 1'b0;
    m_held  = 0;
    e_left  = 1'b0;
    e_right = 1'b0;
    e_jump  = 1'b1;
    e_pulse = 1'b0;
  endtask

  // One active clock edge with reset released. All right-hand values are
  // those present just before the edge.
  task automatic model_step();
    logic [2:0] raw;
    logic [2:0] rise;
    logic       pressed_s;
    raw  = {key_j, key_r, key_l};
    m_cyc++;
    rise = m_lvl & ~m_prev;
    for (int c = 0; c < 3; c++)
      if (rise[c]) m_t_rise[c] = m_cyc;

`ifdef BUTTON_CONDITIONER_LR_EXCLUSIVE_EN
    e_left  = m_lvl[0] && (!m_lvl[1] || (m_t_rise[0] > m_t_rise[1]));
    e_right = m_lvl[1] && (!m_lvl[0] || (m_t_rise[1] > m_t_rise[0]));
`else
    e_left  = m_lvl[0];
    e_right = m_lvl[1];
`endif

    e_pulse = rise[2];
    if (rise[2]) begin
      m_jlow = 1'b1;
      m_held = 1;
    end else if (m_jlow) begin
      if (!m_lvl[2] || m_held == H) m_jlow = 1'b0;
      else m_held++;
    end
    e_jump = !m_jlow;

    m_prev = m_lvl;
    for (int c = 0; c < 3; c++) begin
      pressed_s = !m_s2[c];
      if (pressed_s != m_lvl[c]) begin
        m_run[c]++;
        if (m_run[c] == D + 1) begin
          m_lvl[c] = pressed_s;
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".left"},       32'(left),       32'(e_left));
    check({tag, ".right"},      32'(right),      32'(e_right));
    check({tag, ".jump"},       32'(jump),       32'(e_jump));
    check({tag, ".jump_pulse"}, 32'(jump_pulse), 32'(e_pulse));
  endtask

  // Advance one edge, update the model, and compare 1 time unit later.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check_outputs(tag);
  endtask

  // Assert reset away from the clock edge and check the immediate effect.
  task automatic async_reset(input int hold_cycles);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    repeat (hold_cycles) tick("in_rst");
    #3 rst_n = 1'b1;
  endtask

  int first;
  int cnt_low;
  int cnt_pulse;

  initial begin
    model_reset();
    m_cyc = 0;

    // ---- reset with all keys held ----
    key_l = 1'b0; key_r = 1'b0; key_j = 1'b0;
    repeat (3) tick("rst_hold");
    #3 rst_n = 1'b1;
    first     = -1;
    cnt_pulse = 0;
    for (int i = 0; i < 20; i++) begin
      tick("rst_rel");
      if (left && first < 0) first = i;
      if (jump_pulse) cnt_pulse++;
    end
    check("rst_left_latency", 32'(first), 32'd7);
    check("rst_pulse_count", 32'(cnt_pulse), 32'd1);

    // ---- release everything, settle ----
    key_l = 1'b1; key_r = 1'b1; key_j = 1'b1;
    repeat (20) tick("settle");

    // ---- bounce rejection on left ----
    for (int i = 0; i < 40; i++) begin
      key_l = ((i / 2) % 2) != 0;
      tick("bounce");
    end
    key_l = 1'b0;
    first = -1;
    for (int i = 0; i < 20; i++) begin
      tick("bounce_settle");
      if (left && first < 0) first = i;
    end
    check("bounce_latency", 32'(first), 32'd7);
    key_l = 1'b1;
    repeat (20) tick("settle");

    // ---- jump hold limit ----
    key_j     = 1'b0;
    cnt_low   = 0;
    cnt_pulse = 0;
    for (int i = 0; i < 50; i++) begin
      tick("jump_hold");
      if (!jump) cnt_low++;
      if (jump_pulse) cnt_pulse++;
    end
    check("hold_low_cycles", 32'(cnt_low), 32'(H));
    check("hold_pulse_count", 32'(cnt_pulse), 32'd1);
    key_j = 1'b1;
    repeat (20) tick("settle");

    // ---- short jumps: press 12, release, wait 20, press again ----
    cnt_pulse = 0;
    key_j = 1'b0;
    for (int i = 0; i < 12; i++) begin tick("short1"); if (jump_pulse) cnt_pulse++; end
    key_j = 1'b1;
    for (int i = 0; i < 20; i++) begin tick("short_gap"); if (jump_pulse) cnt_pulse++; end
    key_j = 1'b0;
    for (int i = 0; i < 12; i++) begin tick("short2"); if (jump_pulse) cnt_pulse++; end
    key_j = 1'b1;
    for (int i = 0; i < 20; i++) begin tick("short_tail"); if (jump_pulse) cnt_pulse++; end
    check("short_pulse_count", 32'(cnt_pulse), 32'd2);

    // ---- mid-hold reset with key still held ----
    key_j = 1'b0;
    first = -1;
    for (int i = 0; i < 30 && first < 0; i++) begin
      tick("mid_press");
      if (!jump) first = i;
    end
    check("mid_hold_entered", 32'(first >= 0), 32'd1);
    repeat (3) tick("mid_hold");
    async_reset(2);
    first = -1;
    for (int i = 0; i < 20; i++) begin
      tick("mid_rearm");
      if (!jump && first < 0) first = i;
    end
    check("mid_rearm_latency", 32'(first), 32'd7);
    key_j = 1'b1;
    repeat (30) tick("settle");

    // ---- left/right exclusivity scenario ----
    key_l = 1'b0;
    repeat (20) tick("lr_left");
    key_r = 1'b0;
    repeat (20) tick("lr_both");
    key_r = 1'b1;
    repeat (20) tick("lr_right_rel");
    key_l = 1'b1;
    repeat (20) tick("lr_settle");
    // simultaneous press on both directions
    key_l = 1'b0; key_r = 1'b0;
    repeat (20) tick("lr_simul");
    key_l = 1'b1;
    repeat (20) tick("lr_simul_rel");
    key_r = 1'b1;
    repeat (20) tick("settle");

    // ---- randomized phase ----
    for (int seg = 0; seg < 60; seg++) begin
      int unsigned p;
      p = ($urandom_range(0, 1) != 0) ? 3 : 40;
      for (int i = 0; i < 50; i++) begin
        if ($urandom_range(0, p - 1) == 0) key_l = ~key_l;
        if ($urandom_range(0, p - 1) == 0) key_r = ~key_r;
        if ($urandom_range(0, p - 1) == 0) key_j = ~key_j;
        tick("rand");
        if ($urandom_range(0, 299) == 0) async_reset(int'($urandom_range(1, 3)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
